m23lc512_spi_sram: RTL and testbench

Synthesizable SPI-slave SRAM emulating the 23LC512 serial SRAM command set (single-I/O SPI mode 0 only). It oversamples the external SPI pins with the system clock and serves an internal byte array. It sits on the SoC's SPI0 pins as the off-chip scratch memory.

---
 rtl/m23lc512_pkg.sv | 16 +
 rtl/spi_pin_sync.sv | 33 +++
 rtl/m23lc512_spi_sram.sv | 202 ++++++++++++++++++++
 tb/tb_m23lc512_spi_sram.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m23lc512_pkg.sv
// Shared constants and state encoding for the 23LC512-compatible SPI SRAM.
package m23lc512_pkg;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA_RD, ST_DATA_WR, ST_MR_RD, ST_MR_WR, ST_IGNORE
  } state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin with edge detect on the synchronized level.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;
endmodule

// File: rtl/m23lc512_spi_sram.sv
// SPI mode-0 slave emulating the 23LC512 serial SRAM, oversampled by HCLK.
// Optional HOLD_N pin support is built when SRAM_HOLD_EN is defined.
module m23lc512_spi_sram
  import m23lc512_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int PAGE_BYTES = 32
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic CS_N,
  input  logic SCK,
  input  logic SI,
`ifdef SRAM_HOLD_EN
  input  logic HOLD_N,
`endif
  output logic SO,
  output logic SO_OE
);
  localparam logic [ADDR_W-1:0] PG_MASK = ADDR_W'(PAGE_BYTES - 1);

  logic cs_n_s, sck_rise, sck_fall, si_s, hold_act;
  logic unused_cs_rise, unused_cs_fall, unused_sck_lvl, unused_si_rise, unused_si_fall;

  spi_pin_sync #(.RST_VAL(1'b1)) u_cs  (.clk(HCLK), .rst_n(HRESETn), .d(CS_N), .q(cs_n_s),
                                        .rise(unused_cs_rise), .fall(unused_cs_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_sck (.clk(HCLK), .rst_n(HRESETn), .d(SCK), .q(unused_sck_lvl),
                                        .rise(sck_rise), .fall(sck_fall));
  spi_pin_sync #(.RST_VAL(1'b0)) u_si  (.clk(HCLK), .rst_n(HRESETn), .d(SI), .q(si_s),
                                        .rise(unused_si_rise), .fall(unused_si_fall));

`ifdef SRAM_HOLD_EN
  logic hold_n_s, unused_hold_rise, unused_hold_fall;
  spi_pin_sync #(.RST_VAL(1'b1)) u_hold (.clk(HCLK), .rst_n(HRESETn), .d(HOLD_N), .q(hold_n_s),
                                         .rise(unused_hold_rise), .fall(unused_hold_fall));
  assign hold_act = ~hold_n_s;
`else
  assign hold_act = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic              is_rd_q, is_rd_d;
  logic              done_q, done_d;
  logic [2:0]        rd_bit_q, rd_bit_d;
  logic [7:0]        rd_byte_q, rd_byte_d;
  logic              so_q, so_d, so_oe_q, so_oe_d;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] mem_rdata_q;
  logic       mem_we;
  logic [7:0] in_byte, out_src, out_byte;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] m);
    logic [ADDR_W-1:0] inc;
    inc = a + ADDR_W'(1);
    // Page mode only carries within the page; reserved mode behaves as sequential.
    if (m == MODE_PAGE) return (a & ~PG_MASK) | (inc & PG_MASK);
    return inc;
  endfunction

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    is_rd_d   = is_rd_q;
    done_d    = done_q;
    rd_bit_d  = rd_bit_q;
    rd_byte_d = rd_byte_q;
    so_d      = so_q;
    so_oe_d   = so_oe_q;
    mem_we    = 1'b0;
    in_byte   = {shift_q[6:0], si_s};
    out_src   = (state_q == ST_MR_RD) ? {mode_q, 6'b0} : mem_rdata_q;
    out_byte  = (rd_bit_q == 3'd7) ? out_src : rd_byte_q;

    if (cs_n_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      so_oe_d   = 1'b0;
      done_d    = 1'b0;
    end else if (!hold_act) begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = 4'd0;
        end
        ST_CMD: if (sck_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            rd_bit_d  = 3'd7;
            done_d    = 1'b0;
            case (in_byte)
              OP_READ:  begin state_d = ST_ADDR; is_rd_d = 1'b1; end
              OP_WRITE: begin state_d = ST_ADDR; is_rd_d = 1'b0; end
              OP_RDMR:  state_d = ST_MR_RD;
              OP_WRMR:  state_d = ST_MR_WR;
              default:  state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (sck_rise) begin
          // Shifting through an ADDR_W-wide register drops the unused upper address bits.
          addr_d    = {addr_q[ADDR_W-2:0], si_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = 4'd0;
            state_d   = is_rd_q ? ST_DATA_RD : ST_DATA_WR;
          end
        end
        ST_DATA_RD, ST_MR_RD: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_DATA_RD) begin
                if (mode_q == MODE_BYTE) done_d = 1'b1;
                else                     addr_d = next_addr(addr_q, mode_q);
              end
            end
          end
          if (sck_fall) begin
            if (done_q) begin
              so_oe_d = 1'b0;
            end else begin
              so_d    = out_byte[rd_bit_q];
              so_oe_d = 1'b1;
              if (rd_bit_q == 3'd7) rd_byte_d = out_src;
              rd_bit_d = rd_bit_q - 3'd1;
            end
          end
        end
        ST_DATA_WR: if (sck_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (!done_q) begin
              mem_we = 1'b1;
              addr_d = next_addr(addr_q, mode_q);
              if (mode_q == MODE_BYTE) done_d = 1'b1;
            end
          end
        end
        ST_MR_WR: if (sck_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (in_byte[7:6] != MODE_RSVD) mode_d = in_byte[7:6];
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      addr_q    <= '0;
      mode_q    <= MODE_SEQ;
      is_rd_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_bit_q  <= 3'd7;
      rd_byte_q <= 8'd0;
      so_q      <= 1'b0;
      so_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      is_rd_q   <= is_rd_d;
      done_q    <= done_d;
      rd_bit_q  <= rd_bit_d;
      rd_byte_q <= rd_byte_d;
      so_q      <= so_d;
      so_oe_q   <= so_oe_d;
    end
  end

  // Single-port byte RAM; contents deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) mem[addr_q] <= in_byte;
    mem_rdata_q <= mem[addr_q];
  end

  assign SO    = so_q;
  assign SO_OE = so_oe_q & ~hold_act;
endmodule

// File: tb/tb_m23lc512_spi_sram.sv
// Self-checking bench for m23lc512_spi_sram: bit-banged SPI master plus byte-array reference model.
module tb_m23lc512_spi_sram;
  localparam int HALF = 60;

  logic HCLK, HRESETn, CS_N, SCK, SI, SO, SO_OE;
`ifdef SRAM_HOLD_EN
  logic HOLD_N;
`endif

  m23lc512_spi_sram dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .CS_N(CS_N), .SCK(SCK), .SI(SI),
`ifdef SRAM_HOLD_EN
    .HOLD_N(HOLD_N),
`endif
    .SO(SO), .SO_OE(SO_OE)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem_m [0:65535];
  logic [1:0] mode_m;
  logic [7:0] buf_w [0:15];
  logic [7:0] buf_r [0:15];
  logic       oe_all [0:15];
  logic       oe_any [0:15];

  function automatic logic [15:0] adv(input logic [15:0] a);
    if (mode_m == 2'b10) return {a[15:5], a[4:0] + 5'd1};
    return a + 16'd1;
  endfunction

  function automatic logic [7:0] model_at(input logic [15:0] a, input int k);
    logic [15:0] p;
    p = a;
    for (int i = 0; i < k; i++) p = adv(p);
    return mem_m[p];
  endfunction

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic all, output logic any);
    rx = 8'd0; all = 1'b1; any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      SI = tx[i];
      #HALF;
      rx[i] = SO; all = all & SO_OE; any = any | SO_OE;
      SCK = 1'b1;
      #HALF;
      SCK = 1'b0;
    end
  endtask

  task automatic cs_begin();
    CS_N = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF;
    CS_N = 1'b1;
    #(HALF * 2);
  endtask

  task automatic spi_write(input logic [15:0] a, input int n);
    logic [7:0] r; logic x, y; logic [15:0] p;
    cs_begin();
    xfer(8'h02, r, x, y); xfer(a[15:8], r, x, y); xfer(a[7:0], r, x, y);
    for (int k = 0; k < n; k++) xfer(buf_w[k], r, x, y);
    cs_end();
    p = a;
    for (int k = 0; k < n; k++) begin
      if (mode_m == 2'b00 && k > 0) break;
      mem_m[p] = buf_w[k];
      p = adv(p);
    end
  endtask

  task automatic spi_read(input logic [15:0] a, input int n);
    logic [7:0] r; logic x, y;
    cs_begin();
    xfer(8'h03, r, x, y); xfer(a[15:8], r, x, y); xfer(a[7:0], r, x, y);
    for (int k = 0; k < n; k++) xfer(8'h00, buf_r[k], oe_all[k], oe_any[k]);
    cs_end();
  endtask

  task automatic spi_wrmr(input logic [7:0] v);
    logic [7:0] r; logic x, y;
    cs_begin();
    xfer(8'h01, r, x, y); xfer(v, r, x, y);
    cs_end();
    if (v[7:6] != 2'b11) mode_m = v[7:6];
  endtask

  task automatic spi_rdmr(input int n);
    logic [7:0] r; logic x, y;
    cs_begin();
    xfer(8'h05, r, x, y);
    for (int k = 0; k < n; k++) xfer(8'h00, buf_r[k], oe_all[k], oe_any[k]);
    cs_end();
  endtask

  task automatic test_reset();
    n_chk++;
    if (SO_OE !== 1'b0) begin n_fail++; $display("FAIL reset_so_oe: got %b want 0", SO_OE); end
    n_chk++;
    if (SO !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b want 0", SO); end
    spi_rdmr(2);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (buf_r[k] !== 8'h40 || oe_all[k] !== 1'b1) begin
        n_fail++; $display("FAIL reset_rdmr[%0d]: got %h oe %b want 40 oe 1", k, buf_r[k], oe_all[k]);
      end
    end
  endtask

  task automatic test_basic();
    buf_w[0] = 8'hA5; buf_w[1] = 8'h5A;
    spi_write(16'h0010, 2);
    spi_read(16'h0010, 2);
    n_chk++;
    if (buf_r[0] !== 8'hA5 || oe_all[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_b0: got %h oe %b want a5 oe 1", buf_r[0], oe_all[0]);
    end
    n_chk++;
    if (buf_r[1] !== 8'h5A || oe_all[1] !== 1'b1) begin
      n_fail++; $display("FAIL basic_b1: got %h oe %b want 5a oe 1", buf_r[1], oe_all[1]);
    end
  endtask

  task automatic test_seq_wrap();
    buf_w[0] = 8'h11; buf_w[1] = 8'h22;
    spi_write(16'hFFFF, 2);
    spi_read(16'h0000, 1);
    n_chk++;
    if (buf_r[0] !== 8'h22) begin n_fail++; $display("FAIL seq_wrap_0000: got %h want 22", buf_r[0]); end
    spi_read(16'hFFFF, 2);
    n_chk++;
    if (buf_r[0] !== 8'h11 || buf_r[1] !== 8'h22) begin
      n_fail++; $display("FAIL seq_wrap_read: got %h %h want 11 22", buf_r[0], buf_r[1]);
    end
  endtask

  task automatic test_page();
    logic [7:0] old20;
    old20 = 8'($urandom);
    buf_w[0] = old20;
    spi_write(16'h0020, 1);
    spi_wrmr(8'h80);
    spi_rdmr(1);
    n_chk++;
    if (buf_r[0] !== 8'h80) begin n_fail++; $display("FAIL page_rdmr: got %h want 80", buf_r[0]); end
    buf_w[0] = 8'h33; buf_w[1] = 8'h44;
    spi_write(16'h001F, 2);
    spi_read(16'h0000, 1);
    n_chk++;
    if (buf_r[0] !== 8'h44) begin n_fail++; $display("FAIL page_wrap_0000: got %h want 44", buf_r[0]); end
    spi_read(16'h0020, 1);
    n_chk++;
    if (buf_r[0] !== old20) begin n_fail++; $display("FAIL page_0020_kept: got %h want %h", buf_r[0], old20); end
    spi_read(16'h001F, 2);
    n_chk++;
    if (buf_r[0] !== 8'h33 || buf_r[1] !== 8'h44) begin
      n_fail++; $display("FAIL page_read_wrap: got %h %h want 33 44", buf_r[0], buf_r[1]);
    end
  endtask

  task automatic test_byte_mode();
    logic [7:0] old101;
    spi_wrmr(8'h40);
    old101 = 8'($urandom);
    buf_w[0] = old101;
    spi_write(16'h0101, 1);
    spi_wrmr(8'h00);
    buf_w[0] = 8'h77; buf_w[1] = 8'h88;
    spi_write(16'h0100, 2);
    spi_read(16'h0101, 1);
    n_chk++;
    if (buf_r[0] !== old101) begin n_fail++; $display("FAIL byte_0101_kept: got %h want %h", buf_r[0], old101); end
    spi_read(16'h0100, 2);
    n_chk++;
    if (buf_r[0] !== 8'h77 || oe_all[0] !== 1'b1) begin
      n_fail++; $display("FAIL byte_first: got %h oe %b want 77 oe 1", buf_r[0], oe_all[0]);
    end
    n_chk++;
    if (oe_any[1] !== 1'b0) begin n_fail++; $display("FAIL byte_oe_drop: got oe %b want 0", oe_any[1]); end
    spi_wrmr(8'hC0);
    spi_rdmr(1);
    n_chk++;
    if (buf_r[0] !== 8'h00) begin n_fail++; $display("FAIL wrmr_rsvd_ignored: got %h want 00", buf_r[0]); end
    spi_wrmr(8'h40);
  endtask

  task automatic test_partial_write();
    logic [7:0] r; logic x, y;
    buf_w[0] = 8'($urandom);
    spi_write(16'h0200, 1);
    cs_begin();
    xfer(8'h02, r, x, y); xfer(8'h02, r, x, y); xfer(8'h00, r, x, y);
    for (int i = 0; i < 5; i++) begin
      SI = ~buf_w[0][7-i]; #HALF; SCK = 1'b1; #HALF; SCK = 1'b0;
    end
    cs_end();
    spi_read(16'h0200, 1);
    n_chk++;
    if (buf_r[0] !== mem_m[16'h0200]) begin
      n_fail++; $display("FAIL partial_no_store: got %h want %h", buf_r[0], mem_m[16'h0200]);
    end
  endtask

  task automatic test_cs_abort();
    logic [7:0] r; logic x, y;
    cs_begin();
    xfer(8'h03, r, x, y); xfer(8'h00, r, x, y); xfer(8'h10, r, x, y);
    for (int i = 0; i < 3; i++) begin
      #HALF; SCK = 1'b1; #HALF; SCK = 1'b0;
    end
    #HALF;
    n_chk++;
    if (SO_OE !== 1'b1) begin n_fail++; $display("FAIL abort_pre_oe: got %b want 1", SO_OE); end
    CS_N = 1'b1;
    #40;
    n_chk++;
    if (SO_OE !== 1'b0) begin n_fail++; $display("FAIL abort_oe_drop: got %b want 0", SO_OE); end
    #(HALF * 2);
  endtask

`ifdef SRAM_HOLD_EN
  task automatic test_hold();
    logic [7:0] r, b0, b1; logic x, y;
    buf_w[0] = 8'($urandom); buf_w[1] = 8'($urandom);
    spi_write(16'h0300, 2);
    cs_begin();
    xfer(8'h03, r, x, y); xfer(8'h03, r, x, y); xfer(8'h00, r, x, y);
    b0 = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        HOLD_N = 1'b0; #HALF;
        n_chk++;
        if (SO_OE !== 1'b0) begin n_fail++; $display("FAIL hold_oe: got %b want 0", SO_OE); end
        for (int j = 0; j < 16; j++) begin SCK = 1'b1; #HALF; SCK = 1'b0; #HALF; end
        HOLD_N = 1'b1;
      end
      #HALF; b0[i] = SO; SCK = 1'b1; #HALF; SCK = 1'b0;
    end
    xfer(8'h00, b1, x, y);
    cs_end();
    n_chk++;
    if (b0 !== buf_w[0] || b1 !== buf_w[1]) begin
      n_fail++; $display("FAIL hold_resume: got %h %h want %h %h", b0, b1, buf_w[0], buf_w[1]);
    end
  endtask
`endif

  task automatic test_random();
    logic [1:0] m; logic [15:0] a; int n, sel;
    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(0, 2);
      m = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b10;
      spi_wrmr({m, 6'($urandom)});
      spi_rdmr(1);
      n_chk++;
      if (buf_r[0] !== {m, 6'b0}) begin n_fail++; $display("FAIL rand_rdmr: got %h want %h", buf_r[0], {m, 6'b0}); end
      a = 16'($urandom);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) buf_w[k] = 8'($urandom);
      spi_write(a, n);
      spi_read(a, n);
      for (int k = 0; k < n; k++) begin
        n_chk++;
        if (m == 2'b00 && k > 0) begin
          if (oe_any[k] !== 1'b0) begin
            n_fail++; $display("FAIL rand_byte_oe a=%h k=%0d: got oe %b want 0", a, k, oe_any[k]);
          end
        end else if (buf_r[k] !== model_at(a, k) || oe_all[k] !== 1'b1) begin
          n_fail++; $display("FAIL rand_rd a=%h m=%b k=%0d: got %h oe %b want %h oe 1",
                             a, m, k, buf_r[k], oe_all[k], model_at(a, k));
        end
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0; CS_N = 1'b1; SCK = 1'b0; SI = 1'b0;
`ifdef SRAM_HOLD_EN
    HOLD_N = 1'b1;
`endif
    mode_m = 2'b01;
    #40;
    HRESETn = 1'b1;
    #40;
    test_reset();
    test_basic();
    test_seq_wrap();
    test_page();
    test_byte_mode();
    test_partial_write();
    test_cs_abort();
`ifdef SRAM_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
